// File: rtl/embed_stream_pkg.sv
// Shared types and constants for the embedding token streamer.
// Holds the FSM state type, default geometry, Q4.4 limits and the saturating adder
// used when the POS_EMBED_EN build option is enabled.
package embed_stream_pkg;

    typedef enum logic {
        StIdle,
        StStream
    } state_t;

    localparam int unsigned DEF_ROWS = 15;
    localparam int unsigned DEF_COLS = 16;
    localparam int unsigned DEF_DW   = 8;

    localparam logic [7:0] Q44_MIN = 8'h80;  // -8.0
    localparam logic [7:0] Q44_MAX = 8'h7F;  // +7.9375

    // Signed Q4.4 add at 9 bits, clamped back into the 8-bit range.
    function automatic logic [7:0] sat_add_q44(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {a[7], a} + {b[7], b};
        // Bits 8 and 7 disagree only when the true sum left the 8-bit range.
        if (sum[8] != sum[7]) begin
            return sum[8] ? Q44_MIN : Q44_MAX;
        end
        return sum[7:0];
    endfunction

endpackage

// File: rtl/embed_snapshot_buf.sv
// Snapshot buffer: ROWS x COLS register array loaded in one cycle, with an
// asynchronous (combinational) row/col read port. Contents need no reset.
module embed_snapshot_buf
    import embed_stream_pkg::*;
#(
    parameter int unsigned ROWS = DEF_ROWS,
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned DW   = DEF_DW
) (
    input  logic                                 clk,
    input  logic                                 cap_en,
    input  logic [0:ROWS-1][0:COLS-1][DW-1:0]    wr_mat,
    input  logic [$clog2(ROWS)-1:0]              rd_row,
    input  logic [$clog2(COLS)-1:0]              rd_col,
    output logic [DW-1:0]                        rd_data
);

    logic [0:ROWS-1][0:COLS-1][DW-1:0] mem;

    // Whole-matrix capture on the producer's done pulse.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            mem <= wr_mat;
        end
    end

    assign rd_data = mem[rd_row][rd_col];

endmodule

// File: rtl/embedding_token_streamer.sv
// Snapshots the embedding matrix on in_done and streams it row-major, one element
// per valid/ready beat. Build option POS_EMBED_EN adds a pos_emb input that is
// saturating-added to every element before the out_data register.
module embedding_token_streamer
    import embed_stream_pkg::*;
#(
    parameter int unsigned ROWS = DEF_ROWS,
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned DW   = DEF_DW
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [0:ROWS-1][0:COLS-1][DW-1:0]    in_mat,
    input  logic                                 in_done,
`ifdef POS_EMBED_EN
    input  logic [0:ROWS-1][0:COLS-1][DW-1:0]    pos_emb,
`endif
    output logic [DW-1:0]                        out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [$clog2(ROWS)-1:0]              out_row,
    output logic [$clog2(COLS)-1:0]              out_col,
    output logic                                 out_row_last,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 drop_err
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);

    state_t          state_q;
    logic            hs;
    logic            capture;
    logic            valid_n;
    logic [RW-1:0]   row_n;
    logic [CW-1:0]   col_n;
    logic [DW-1:0]   rd_data;
    logic [DW-1:0]   elem;
    logic [DW-1:0]   data_n;

    embed_snapshot_buf #(
        .ROWS (ROWS),
        .COLS (COLS),
        .DW   (DW)
    ) u_buf (
        .clk     (clk),
        .cap_en  (capture),
        .wr_mat  (in_mat),
        .rd_row  (row_n),
        .rd_col  (col_n),
        .rd_data (rd_data)
    );

    // Next beat position: capture restarts at (0,0), a handshake advances row-major.
    always_comb begin
        hs      = out_valid && out_ready;
        // A new matrix is taken when idle, or exactly as the final beat is accepted.
        capture = in_done && ((state_q == StIdle) || (hs && out_last));
        row_n   = out_row;
        col_n   = out_col;
        valid_n = (state_q == StStream);
        if (capture) begin
            row_n   = '0;
            col_n   = '0;
            valid_n = 1'b1;
        end else if (hs) begin
            if (out_last) begin
                row_n   = '0;
                col_n   = '0;
                valid_n = 1'b0;
            end else if (out_col == CW'(COLS - 1)) begin
                row_n = out_row + RW'(1);
                col_n = '0;
            end else begin
                col_n = out_col + CW'(1);
            end
        end
    end

    // Element for the next beat; the buffer is not yet loaded in the capture cycle,
    // so (0,0) is taken straight from the input matrix.
    always_comb begin
        elem = capture ? in_mat[0][0] : rd_data;
`ifdef POS_EMBED_EN
        data_n = sat_add_q44(elem, pos_emb[row_n][col_n]);
`else
        data_n = elem;
`endif
    end

    // FSM, beat counters and registered stream outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            out_row      <= '0;
            out_col      <= '0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            out_row_last <= 1'b0;
            out_last     <= 1'b0;
            busy         <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            state_q      <= valid_n ? StStream : StIdle;
            out_row      <= row_n;
            out_col      <= col_n;
            out_data     <= data_n;
            out_valid    <= valid_n;
            busy         <= valid_n;
            out_row_last <= valid_n && (col_n == CW'(COLS - 1));
            out_last     <= valid_n && (row_n == RW'(ROWS - 1)) && (col_n == CW'(COLS - 1));
            if (in_done && (state_q == StStream) && !capture) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_embedding_token_streamer.sv
// Directed bench for embedding_token_streamer: a scenario table (plain stream,
// backpressure, dropped pulse, back-to-back, mid-stream reset) plus, when
// POS_EMBED_EN is defined, a table of saturating-add vectors.
module tb_embedding_token_streamer;

    localparam int ROWS = 15;
    localparam int COLS = 16;
    localparam int DW   = 8;
    localparam int NB   = ROWS * COLS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                              rst;
    logic                              in_done;
    logic                              out_ready;
    logic [0:ROWS-1][0:COLS-1][DW-1:0] in_mat;
`ifdef POS_EMBED_EN
    logic [0:ROWS-1][0:COLS-1][DW-1:0] pos_emb;
`endif
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [3:0]    out_row;
    logic [3:0]    out_col;
    logic          out_row_last;
    logic          out_last;
    logic          busy;
    logic          drop_err;

    int total = 0;
    int bad   = 0;

    embedding_token_streamer dut (
        .clk          (clk),
        .rst          (rst),
        .in_mat       (in_mat),
        .in_done      (in_done),
`ifdef POS_EMBED_EN
        .pos_emb      (pos_emb),
`endif
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_row_last (out_row_last),
        .out_last     (out_last),
        .busy         (busy),
        .drop_err     (drop_err)
    );

    typedef struct {
        int   seed;
        int   mode;      // 0: ready always high, 1: ready pattern 1,0,0,1
        int   drop_at;   // beat at which a stray in_done is pulsed, -1 none
        int   abort_at;  // beat at which rst is pulsed, -1 none
        int   b2b_seed;  // seed of a matrix captured with the final beat, -1 none
        int   exp_beats;
        logic exp_drop;
    } scen_t;

    scen_t sc [0:4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gen(input int seed, input int r, input int c);
        return 8'((r * COLS + c + seed) & 255);
    endfunction

    function automatic logic [31:0] exp_beat(input int seed, input int k);
        int r;
        int c;
        r = k / COLS;
        c = k % COLS;
        return {14'd0, gen(seed, r, c), 4'(r), 4'(c), (c == COLS - 1), (k == NB - 1)};
    endfunction

    function automatic logic [31:0] act_beat();
        return {14'd0, out_data, out_row, out_col, out_row_last, out_last};
    endfunction

    task automatic set_input(input int seed);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                in_mat[r][c] = gen(seed, r, c);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_done = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_state", {19'd0, out_valid, busy, drop_err, out_data, out_row_last,
                              out_last}, 32'd0);
        check("reset_counters", {24'd0, out_row, out_col}, 32'd0);
    endtask

    // Idle with ready toggling (must have no effect), then one in_done pulse.
    task automatic start_stream(input int seed);
        for (int i = 0; i < 8; i++) begin
            out_ready = i[0];
            tick();
        end
        check("idle_no_effect", {22'd0, out_valid, busy, out_row, out_col}, 32'd0);
        set_input(seed);
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        check("first_beat_latency", {30'd0, out_valid, busy}, 32'd3);
    endtask

    task automatic consume(input int seed, input int mode, input int drop_at,
                           input int abort_at, input int b2b_seed, output int nbeats);
        int   k;
        int   cyc;
        int   nrl;
        int   nl;
        bit   fin;
        bit   dropped;
        logic rdy;
        k = 0; cyc = 0; nrl = 0; nl = 0; fin = 1'b0; dropped = 1'b0;
        while (!fin && cyc < 4 * NB) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            out_ready = rdy;
            in_done = 1'b0;
            if (!out_valid) begin
                check($sformatf("valid_beat%0d", k), {31'd0, out_valid}, 32'd1);
                fin = 1'b1;
            end else if (k == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("abort_state", {22'd0, out_valid, busy, out_row, out_col}, 32'd0);
                check("abort_flags", {30'd0, out_row_last, out_last}, 32'd0);
                fin = 1'b1;
            end else begin
                check($sformatf("beat%0d", k), act_beat(), exp_beat(seed, k));
                if (k == drop_at && !dropped) begin
                    set_input(seed + 100);
                    in_done = 1'b1;
                    dropped = 1'b1;
                end
                if (rdy) begin
                    if (out_row_last) nrl++;
                    if (out_last) nl++;
                    if (k == NB - 1) begin
                        fin = 1'b1;
                        if (b2b_seed >= 0) begin
                            set_input(b2b_seed);
                            in_done = 1'b1;
                        end
                    end
                    k++;
                end
                tick();
                in_done = 1'b0;
                cyc++;
            end
        end
        check("stream_in_time", {31'd0, fin}, 32'd1);
        if (k == NB) begin
            check("row_last_count", nrl, 15);
            check("last_count", nl, 1);
            if (b2b_seed < 0)
                check("idle_after_last", {30'd0, out_valid, busy}, 32'd0);
        end
        nbeats = k;
    endtask

`ifdef POS_EMBED_EN
    typedef struct {
        logic [7:0] b;
        logic [7:0] p;
        logic [7:0] exp;
    } pvec_t;
    pvec_t pv [0:2];
`endif

    initial begin
        int n;
        rst = 1'b1;
        in_done = 1'b0;
        out_ready = 1'b0;
        in_mat = '0;
`ifdef POS_EMBED_EN
        pos_emb = '0;
`endif

        sc[0] = '{seed: 0,  mode: 0, drop_at: -1, abort_at: -1,  b2b_seed: -1,  exp_beats: 240,
                  exp_drop: 1'b0};
        sc[1] = '{seed: 7,  mode: 1, drop_at: -1, abort_at: -1,  b2b_seed: -1,  exp_beats: 240,
                  exp_drop: 1'b0};
        sc[2] = '{seed: 3,  mode: 0, drop_at: 50, abort_at: -1,  b2b_seed: -1,  exp_beats: 240,
                  exp_drop: 1'b1};
        sc[3] = '{seed: 11, mode: 1, drop_at: -1, abort_at: -1,  b2b_seed: 200, exp_beats: 240,
                  exp_drop: 1'b0};
        sc[4] = '{seed: 5,  mode: 0, drop_at: -1, abort_at: 100, b2b_seed: -1,  exp_beats: 100,
                  exp_drop: 1'b0};

        for (int i = 0; i < 5; i++) begin
            do_reset();
            start_stream(sc[i].seed);
            consume(sc[i].seed, sc[i].mode, sc[i].drop_at, sc[i].abort_at, sc[i].b2b_seed, n);
            check($sformatf("beats_s%0d", i), n, sc[i].exp_beats);
            check($sformatf("drop_err_s%0d", i), {31'd0, drop_err}, {31'd0, sc[i].exp_drop});
            if (sc[i].b2b_seed >= 0) begin
                consume(sc[i].b2b_seed, 0, -1, -1, -1, n);
                check("beats_b2b", n, NB);
                check("drop_err_b2b", {31'd0, drop_err}, 32'd0);
            end
            if (sc[i].abort_at >= 0) begin
                start_stream(sc[i].seed + 1);
                consume(sc[i].seed + 1, 0, -1, -1, -1, n);
                check("beats_restart", n, NB);
            end
        end

`ifdef POS_EMBED_EN
        pv[0] = '{b: 8'h70, p: 8'h20, exp: 8'h7F};
        pv[1] = '{b: 8'h90, p: 8'hE0, exp: 8'h80};
        pv[2] = '{b: 8'h10, p: 8'h08, exp: 8'h18};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    in_mat[r][c] = pv[i].b;
                    pos_emb[r][c] = pv[i].p;
                end
            in_done = 1'b1;
            out_ready = 1'b1;
            tick();
            in_done = 1'b0;
            check($sformatf("pos_add%0d_first", i), {24'd0, out_data}, {24'd0, pv[i].exp});
            tick();
            check($sformatf("pos_add%0d_second", i), {24'd0, out_data}, {24'd0, pv[i].exp});
        end
        pos_emb = '0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/embedding_token_streamer.md
Name: embedding_token_streamer

Overview:
Consumer-side endpoint of the linear-embedding stage. On the producer's one-cycle done pulse it snapshots the 15x16 Q4.4 embedding matrix into a local buffer. It then streams the matrix one element per beat, in row-major token order, over a valid/ready interface to the downstream encoder. The snapshot decouples the producer, which clears its indices and restarts, from downstream backpressure.

Parameters:
ROWS, 15, number of tokens (matrix rows)
COLS, 16, embedding width (matrix columns)
DW, 8, element width, signed Q4.4

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_mat  input  DW x [0:ROWS-1][0:COLS-1]  embedding matrix, signed Q4.4; valid only in the in_done cycle
in_done  input  1  one-cycle pulse: in_mat complete
out_data  output  DW  streamed element, signed Q4.4
out_valid  output  1  out_data/out_row/out_col valid
out_ready  input  1  downstream accepts the beat
out_row  output  $clog2(ROWS)  token index of the current beat
out_col  output  $clog2(COLS)  column index of the current beat
out_row_last  output  1  beat is column COLS-1
out_last  output  1  beat is (ROWS-1, COLS-1)
busy  output  1  snapshot held, stream in progress
drop_err  output  1  sticky: an in_done was ignored

Behaviour:
- Reset (synchronous, active-high): state IDLE, row/col counters 0, out_valid=0, out_row_last=0, out_last=0, busy=0, drop_err=0, out_data=0. Buffer contents are don't-care. Reset mid-stream aborts immediately; no further beats are presented.
- States: IDLE and STREAM.
- IDLE: an in_done pulse copies all ROWS*COLS elements into the buffer, clears the counters and moves to STREAM. Latency: in_done at cycle N gives out_valid=1 at N+1 with element (0,0).
- STREAM: out_valid=1 and busy=1. A beat transfers on out_valid & out_ready.
- Without a handshake, out_data, out_row, out_col and both last flags stay stable.
- On a handshake: col increments. At col=COLS-1, col wraps to 0 and row increments.
- On the handshake with out_last=1: return to IDLE, and out_valid drops the next cycle.
- out_data = buf[out_row][out_col], registered from the counters. There is no bubble between consecutive beats while out_ready=1, so steady-state throughput is 1 element/cycle.
- Simultaneous events:
  - in_done in the same cycle as the final handshake (out_last accepted): the new matrix is captured, counters clear and the block stays in STREAM. Element (0,0) of the new matrix is presented next cycle, with no IDLE gap.
  - in_done during STREAM at any other time: ignored, the buffer is untouched and drop_err is set. drop_err clears only on rst.
- out_ready while out_valid=0 has no effect.
- A full stream is exactly ROWS*COLS = 240 beats. out_row_last is asserted on 15 of them and out_last on 1.

Optional Feature:
POS_EMBED_EN
- Defined: adds input port pos_emb, DW x [0:ROWS-1][0:COLS-1], signed Q4.4, constant during a stream.
  - Each streamed element is buf[r][c] + pos_emb[r][c], computed at DW+1 bits and saturated to the range [-128, 127] (Q4.4 -8.0 .. +7.9375).
  - Latency and handshake are unchanged; the add sits in the combinational path before the out_data register.
- Undefined: the port is absent and out_data is the raw buffered element.

Decomposition:
- Package embed_stream_pkg:
  - state enum (IDLE, STREAM)
  - ROWS/COLS/DW defaults
  - Q4.4 min/max constants
  - saturating-add function sat_add_q44
- One natural sub-module, embed_snapshot_buf: the ROWS*COLS register array with a capture enable and a row/col read port. The FSM and counters stay in the top.

Test Plan:
- Basic stream: in_mat[r][c]=r*16+c (8-bit wrap), in_done at cycle 10, out_ready=1 -> out_valid rises at cycle 11 and 240 beats follow. out_data matches in order, out_row_last on beats 15, 31, ..., 239, out_last only on beat 239, busy low at cycle 251.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly -> no beat lost or duplicated, and data and flags stay stable during stalls.
- Dropped pulse: in_done again at beat 50 with a different in_mat -> the stream continues with the original data and drop_err=1 until rst.
- Back-to-back: second in_done coincident with the final accepted beat -> the next cycle presents new (0,0) with out_valid=1 and drop_err stays 0.
- Reset mid-operation: rst at beat 100 -> next cycle out_valid=0, busy=0, counters 0. A subsequent in_done restarts cleanly from (0,0).
- POS_EMBED_EN: buf=0x70 (7.0) with pos=0x20 (2.0) -> 0x7F. buf=0x90 with pos=0xE0 -> 0x80. buf=0x10 with pos=0x08 -> 0x18.
